isqrt_seq: RTL and testbench

ISQRT_SEQ -- requirements
Module: isqrt_seq

---
 rtl/isqrt_seq.sv | 105 ++++++++++
 tb/tb_isqrt_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/isqrt_seq.sv
// Sequential integer square root: one root bit per clock, radix-4 restoring.
// Returns floor(sqrt(x)) and the remainder x - root^2 after IN_W/2 cycles.
module isqrt_seq #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  x_in,
  output logic             busy,
  output logic             rdy,
  output logic [OUT_W-1:0] x_out,
  output logic [OUT_W-1:0] rem_out
);

  localparam int ITER  = IN_W / 2;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IN_W-1:0]  rad_q, rad_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [OUT_W+1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] xo_q, xo_d;
  logic [OUT_W-1:0] ro_q, ro_d;

  logic [OUT_W+1:0] r_sh, trial, r_new;
  logic [OUT_W-1:0] q_new;
  logic             ge;

  // One iteration: bring down two radicand bits, try subtracting 4q+1.
  always_comb begin
    r_sh  = (rem_q << 2) | (OUT_W+2)'(rad_q[IN_W-1 -: 2]);
    trial = {root_q, 2'b01};
    ge    = (r_sh >= trial);
    r_new = ge ? (r_sh - trial) : r_sh;
    q_new = {root_q[OUT_W-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    xo_d    = xo_q;
    ro_d    = ro_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rad_d   = x_in;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rad_d  = {rad_q[IN_W-3:0], 2'b00};
        root_d = q_new;
        rem_d  = r_new;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          xo_d    = q_new;
          ro_d    = r_new[OUT_W-1:0];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rad_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      xo_q    <= '0;
      ro_q    <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      xo_q    <= xo_d;
      ro_q    <= ro_d;
    end
  end

  assign busy    = (state_q == S_CALC);
  assign rdy     = (state_q == S_DONE);
  assign x_out   = xo_q;
  assign rem_out = ro_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed and sweep checks for isqrt_seq: values, latency, back-to-back,
// ignored start during CALC, and mid-computation reset.
module tb_isqrt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [21:0] x_in = '0;
  logic        busy, rdy;
  logic [11:0] x_out, rem_out;

  int n_cmp = 0;
  int n_err = 0;

  isqrt_seq #(.IN_W(22), .OUT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .busy(busy), .rdy(rdy), .x_out(x_out), .rem_out(rem_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for rdy, sampling on negedges; returns cycles since acceptance.
  task automatic wait_rdy(output int lat, output int busy_gaps, output int out_moves);
    logic [11:0] xo0, ro0;
    xo0 = x_out; ro0 = rem_out;
    lat = 1; busy_gaps = 0; out_moves = 0;
    while (!rdy && lat < 25) begin
      if (!busy) busy_gaps++;
      if (x_out !== xo0 || rem_out !== ro0) out_moves++;
      @(negedge clk);
      lat++;
    end
    lat--;
  endtask

  // Single transaction from idle, checks result, latency and the one-cycle rdy.
  task automatic run_op(input string tag, input int unsigned x, input int unsigned er, input int unsigned em);
    int lat, gaps, moves;
    @(negedge clk);
    start = 1'b1; x_in = 22'(x);
    @(negedge clk);
    start = 1'b0; x_in = 22'($urandom);
    chk({tag, ".busy"}, busy, 1);
    wait_rdy(lat, gaps, moves);
    chk({tag, ".lat"}, lat, 11);
    chk({tag, ".root"}, x_out, er);
    chk({tag, ".rem"}, rem_out, em);
    if (gaps != 0) chk({tag, ".busy_gaps"}, gaps, 0);
    if (moves != 0) chk({tag, ".out_held"}, moves, 0);
    $display("op %s x=%0d root=%0d rem=%0d lat=%0d", tag, x, x_out, rem_out, lat);
    @(negedge clk);
    if (rdy || busy) chk({tag, ".idle"}, {busy, rdy}, 0);
  endtask

  initial begin
    int lat, gaps, moves, r, n_rdy;
    logic [21:0] rx;
    logic [43:0] sq;

    #1;
    chk("rst.busy", busy, 0);
    chk("rst.rdy", rdy, 0);
    chk("rst.root", x_out, 0);
    chk("rst.rem", rem_out, 0);
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst.idle", {busy, rdy}, 0);

    run_op("zero", 0, 0, 0);
    run_op("max", 4194303, 2047, 4094);
    run_op("mil", 1000000, 1000, 0);
    run_op("two", 2, 1, 1);
    run_op("one", 1, 1, 0);
    run_op("three", 3, 1, 2);
    run_op("sq2047", 4190209, 2047, 0);
    run_op("sq2047m1", 4190208, 2046, 4092);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; x_in = 22'd16;
    @(negedge clk);
    x_in = 22'd25;
    wait_rdy(lat, gaps, moves);
    chk("b2b0.lat", lat, 11);
    chk("b2b0.root", x_out, 4);
    chk("b2b0.rem", rem_out, 0);
    $display("op b2b0 x=16 root=%0d rem=%0d lat=%0d", x_out, rem_out, lat);
    @(negedge clk);
    chk("b2b1.busy", busy, 1);
    x_in = 22'd16;
    wait_rdy(lat, gaps, moves);
    start = 1'b0;
    chk("b2b1.spacing", lat + 1, 12);
    chk("b2b1.root", x_out, 5);
    chk("b2b1.rem", rem_out, 0);
    $display("op b2b1 x=25 root=%0d rem=%0d spacing=%0d", x_out, rem_out, lat + 1);
    @(negedge clk);

    // Start during CALC is ignored.
    @(negedge clk);
    start = 1'b1; x_in = 22'd144;
    @(negedge clk);
    start = 1'b0; x_in = '0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; x_in = 22'd9999;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!rdy && lat < 25) begin @(negedge clk); lat++; end
    chk("ign.lat", lat + 3, 11);
    chk("ign.root", x_out, 12);
    chk("ign.rem", rem_out, 0);
    $display("op ign x=144 root=%0d rem=%0d", x_out, rem_out);
    n_rdy = 0;
    repeat (20) begin @(negedge clk); if (rdy) n_rdy++; end
    chk("ign.no_2nd_rdy", n_rdy, 0);

    // Reset during CALC aborts with no rdy.
    @(negedge clk);
    start = 1'b1; x_in = 22'd1000000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.rdy", rdy, 0);
    chk("abort.root", x_out, 0);
    chk("abort.rem", rem_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_rdy = 0;
    repeat (15) begin @(negedge clk); if (rdy || busy) n_rdy++; end
    chk("abort.quiet", n_rdy, 0);
    $display("op abort root=%0d rem=%0d", x_out, rem_out);
    run_op("after_rst", 81, 9, 0);

    // Exhaustive low range against an incremental floor-sqrt model.
    r = 0;
    for (int x = 0; x < 4096; x++) begin
      if ((r + 1) * (r + 1) <= x) r++;
      run_op("sweep", x, r, x - r * r);
    end

    // Random radicands: root^2 + rem == x and rem <= 2*root.
    for (int i = 0; i < 200; i++) begin
      rx = 22'($urandom);
      @(negedge clk);
      start = 1'b1; x_in = rx;
      @(negedge clk);
      start = 1'b0;
      wait_rdy(lat, gaps, moves);
      sq = 44'(x_out) * 44'(x_out) + 44'(rem_out);
      chk("rand.lat", lat, 11);
      chk("rand.identity", int'(sq), int'(rx));
      chk("rand.rem_bound", int'(rem_out <= 12'(2 * x_out)) & int'(rem_out <= 2 * int'(x_out)), 1);
      $display("op rand x=%0d root=%0d rem=%0d lat=%0d", rx, x_out, rem_out, lat);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
